// File: rtl/i2c_target_regbus_if.sv
// Register-bus bundle between the I2C target (master side) and the register file (slave side).
interface i2c_target_regbus_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic [7:0] reg_rdata;
  logic       reg_rd;

  modport master (output reg_addr, reg_wdata, reg_wr, reg_rd, input reg_rdata);
  modport slave  (input reg_addr, reg_wdata, reg_wr, reg_rd, output reg_rdata);
endinterface

// File: rtl/i2c_target_regbus.sv
// I2C target engine bridging SCL/SDA transfers onto an 8-bit register bus.
// Define I2C_AUTO_INC_EN to auto-increment the pointer after each write strobe and each ACKed read byte.
module i2c_target_regbus #(
  parameter logic [6:0] DEV_ADDR    = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scl_i,
  input  logic                sda_i,
  output logic                sda_oe,
  output logic                busy,
  i2c_target_regbus_if.master regbus
);
  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [3:0] {
    ST_IDLE, ST_DEV_ADDR, ST_DEV_ACK, ST_REG_PTR, ST_PTR_ACK,
    ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_WAIT_STOP
  } state_t;

  logic [NS-1:0] scl_sync, sda_sync;
  logic          scl_d, sda_d;
  logic          scl_s, sda_s;
  logic          scl_rise, scl_fall, start_det, stop_det;

  // Synchronisers reset to the idle-bus level so reset release never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[NS-2:0], scl_i};
      sda_sync <= {sda_sync[NS-2:0], sda_i};
      scl_d    <= scl_sync[NS-1];
      sda_d    <= sda_sync[NS-1];
    end
  end

  assign scl_s     = scl_sync[NS-1];
  assign sda_s     = sda_sync[NS-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  state_t     state;
  logic [7:0] shreg;
  logic [3:0] bit_cnt;
  logic       rw;
  logic       ack_phase;
  logic [7:0] byte_in;

  assign byte_in = {shreg[6:0], sda_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      shreg            <= '0;
      bit_cnt          <= '0;
      rw               <= 1'b0;
      ack_phase        <= 1'b0;
      sda_oe           <= 1'b0;
      busy             <= 1'b0;
      regbus.reg_addr  <= '0;
      regbus.reg_wdata <= '0;
      regbus.reg_wr    <= 1'b0;
      regbus.reg_rd    <= 1'b0;
    end else begin
      regbus.reg_wr <= 1'b0;
      regbus.reg_rd <= 1'b0;
`ifdef I2C_AUTO_INC_EN
      if (regbus.reg_wr) regbus.reg_addr <= regbus.reg_addr + 8'd1;
`endif
      if (stop_det) begin
        state     <= ST_IDLE;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
      end else if (start_det) begin
        state     <= ST_DEV_ADDR;
        sda_oe    <= 1'b0;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
      end else begin
        case (state)
          ST_DEV_ADDR: if (scl_rise) begin
            shreg   <= byte_in;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              rw <= byte_in[0];
              if (byte_in[7:1] == DEV_ADDR) begin
                busy  <= 1'b1;
                state <= ST_DEV_ACK;
              end else begin
                busy  <= 1'b0;
                state <= ST_WAIT_STOP;
              end
            end
          end
          // First fall after the 8th bit starts the ACK, the fall after the 9th ends it.
          ST_DEV_ACK, ST_PTR_ACK, ST_WR_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe    <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              ack_phase <= 1'b0;
              bit_cnt   <= '0;
              if (state == ST_DEV_ACK && rw) begin
                shreg         <= regbus.reg_rdata;
                regbus.reg_rd <= 1'b1;
                sda_oe        <= ~regbus.reg_rdata[7];
                state         <= ST_RD_DATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= (state == ST_DEV_ACK) ? ST_REG_PTR : ST_WR_DATA;
              end
            end
          end
          ST_REG_PTR, ST_WR_DATA: if (scl_rise) begin
            shreg   <= byte_in;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (state == ST_REG_PTR) begin
                regbus.reg_addr <= byte_in;
                state           <= ST_PTR_ACK;
              end else begin
                regbus.reg_wdata <= byte_in;
                regbus.reg_wr    <= 1'b1;
                state            <= ST_WR_ACK;
              end
            end
          end
          // Rotate rather than shift so the outgoing byte stays intact in the register.
          ST_RD_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
                state     <= ST_RD_ACK;
              end else begin
                sda_oe <= ~shreg[6];
                shreg  <= {shreg[6:0], shreg[7]};
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_s) begin
                busy  <= 1'b0;
                state <= ST_WAIT_STOP;
              end else begin
                ack_phase <= 1'b1;
`ifdef I2C_AUTO_INC_EN
                regbus.reg_addr <= regbus.reg_addr + 8'd1;
`endif
              end
            end else if (scl_fall && ack_phase) begin
              ack_phase     <= 1'b0;
              bit_cnt       <= '0;
              shreg         <= regbus.reg_rdata;
              regbus.reg_rd <= 1'b1;
              sda_oe        <= ~regbus.reg_rdata[7];
              state         <= ST_RD_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target_regbus.sv
// Bench for i2c_target_regbus: directed and random I2C transfers checked by a strobe scoreboard
// against a byte-level register/pointer model.
`timescale 1ns/1ps
module tb_i2c_target_regbus;
  localparam int QTR = 8;
`ifdef I2C_AUTO_INC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic sda_oe, busy;
  wire  sda_line = sda_m & ~sda_oe;

  i2c_target_regbus_if rb();

  i2c_target_regbus #(.DEV_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_line),
    .sda_oe(sda_oe), .busy(busy), .regbus(rb)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_wr;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] rf_mem [256];
  logic [7:0] model_mem [256];
  logic [7:0] ptr_m;
  logic [7:0] wbuf [8];
  logic       mem_ready = 1'b0;
  int         total = 0;
  int         bad = 0;

  assign rb.reg_rdata = rf_mem[rb.reg_addr];

  function automatic logic [7:0] init_val(input logic [7:0] i);
    if (i == 8'h00) return 8'hA7;
    if (i == 8'h30) return 8'h5A;
    return i * 8'd29 + 8'h3C;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Register file plus scoreboard monitor.
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) rf_mem[i] <= init_val(8'(i));
      mem_ready <= 1'b1;
    end
    if (rb.reg_wr && rb.reg_rd) begin
      total++; bad++;
      $display("FAIL strobe_overlap: reg_wr and reg_rd both high at %0t", $time);
    end
    if (rb.reg_wr || rb.reg_rd) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL strobe_unexpected: wr=%0b rd=%0b addr=%0h, none expected", rb.reg_wr, rb.reg_rd, rb.reg_addr);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("strobe_kind", 32'(rb.reg_wr), 32'(e.is_wr));
        chk("strobe_addr", 32'(rb.reg_addr), 32'(e.addr));
        if (e.is_wr) chk("strobe_wdata", 32'(rb.reg_wdata), 32'(e.data));
      end
      if (rb.reg_wr) rf_mem[rb.reg_addr] <= rb.reg_wdata;
    end
  end

  task automatic q();
    repeat (QTR) @(posedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; q(); scl = 1'b1; q(); sda_m = 1'b0; q(); scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; q(); scl = 1'b1; q(); sda_m = 1'b1; q();
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    sda_m = b; q(); scl = 1'b1; q(); r = sda_line; q(); scl = 1'b0; q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    bit_xfer(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input bit send_ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(~send_ack, r);
  endtask

  task automatic end_checks();
    repeat (6) @(posedge clk);
    #1;
    chk("busy_after_stop", 32'(busy), 32'd0);
    chk("sda_after_stop", 32'(sda_oe), 32'd0);
  endtask

  // wbuf[0] is the pointer byte, wbuf[1..n-1] are data bytes.
  task automatic wr_txn(input logic [6:0] a, input int n);
    logic ack;
    logic [7:0] p;
    bit m;
    m = (a == 7'h42);
    if (m && n > 0) begin
      p = wbuf[0];
      for (int i = 1; i < n; i++) begin
        exp_q.push_back('{is_wr: 1'b1, addr: p, data: wbuf[i]});
        model_mem[p] = wbuf[i];
        if (AUTO) p = p + 8'd1;
      end
      ptr_m = p;
    end
    i2c_start();
    write_byte({a, 1'b0}, ack);
    chk("dev_ack_wr", 32'(ack), 32'(m));
    chk("busy_after_addr", 32'(busy), 32'(m));
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], ack);
      chk("data_ack", 32'(ack), 32'(m));
      chk("ack_released", 32'(sda_oe), 32'd0);
    end
    i2c_stop();
    end_checks();
  endtask

  task automatic rd_txn(input bit setp, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] d;
    logic [7:0] a;
    logic [7:0] expd [4];
    if (setp) ptr_m = p;
    for (int i = 0; i < n; i++) begin
      a = ptr_m + (AUTO ? 8'(i) : 8'd0);
      exp_q.push_back('{is_wr: 1'b0, addr: a, data: 8'h00});
      expd[i] = model_mem[a];
    end
    if (AUTO) ptr_m = ptr_m + 8'(n - 1);
    i2c_start();
    if (setp) begin
      write_byte({7'h42, 1'b0}, ack);
      chk("dev_ack_ptrw", 32'(ack), 32'd1);
      write_byte(p, ack);
      chk("ptr_ack", 32'(ack), 32'd1);
      i2c_start();
    end
    write_byte({7'h42, 1'b1}, ack);
    chk("dev_ack_rd", 32'(ack), 32'd1);
    chk("busy_in_read", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(i != n - 1, d);
      chk("rd_data", 32'(d), 32'(expd[i]));
    end
    i2c_stop();
    end_checks();
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack;
    logic r;
    int kind;
    int n;
    logic [6:0] a;
    for (int i = 0; i < 256; i++) model_mem[i] = init_val(8'(i));
    ptr_m = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_reg_wr", 32'(rb.reg_wr), 32'd0);
    chk("rst_reg_rd", 32'(rb.reg_rd), 32'd0);
    chk("rst_reg_addr", 32'(rb.reg_addr), 32'd0);
    chk("rst_reg_wdata", 32'(rb.reg_wdata), 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // T1 single write
    wbuf[0] = 8'h05; wbuf[1] = 8'hA5;
    wr_txn(7'h42, 2);
    // T2 combined read of register 0
    rd_txn(1'b1, 8'h00, 1);
    // T3 address mismatch
    wbuf[0] = 8'h11;
    wr_txn(7'h43, 1);
    // T4 burst write across the pointer wrap, then read it back
    wbuf[0] = 8'hFF; wbuf[1] = 8'h11; wbuf[2] = 8'h22;
    wr_txn(7'h42, 3);
    rd_txn(1'b1, 8'hFF, 2);

    // T5 STOP after 4 bits of a data byte
    i2c_start();
    write_byte({7'h42, 1'b0}, ack);
    chk("t5_dev_ack", 32'(ack), 32'd1);
    write_byte(8'h40, ack);
    chk("t5_ptr_ack", 32'(ack), 32'd1);
    ptr_m = 8'h40;
    for (int i = 0; i < 4; i++) bit_xfer(1'(i & 1), r);
    i2c_stop();
    end_checks();
    wbuf[0] = 8'h05; wbuf[1] = 8'hA5;
    wr_txn(7'h42, 2);

    // T6 reset during bit 3 of a read byte (0x5A: bit 5 is 0, so SDA is pulled)
    i2c_start();
    write_byte({7'h42, 1'b0}, ack);
    write_byte(8'h30, ack);
    chk("t6_ptr_ack", 32'(ack), 32'd1);
    i2c_start();
    exp_q.push_back('{is_wr: 1'b0, addr: 8'h30, data: 8'h00});
    write_byte({7'h42, 1'b1}, ack);
    chk("t6_dev_ack", 32'(ack), 32'd1);
    bit_xfer(1'b1, r);
    chk("t6_bit7", 32'(r), 32'd0);
    bit_xfer(1'b1, r);
    chk("t6_bit6", 32'(r), 32'd1);
    sda_m = 1'b1; q(); scl = 1'b1; q();
    chk("t6_oe_before_rst", 32'(sda_oe), 32'd1);
    #3 rst = 1'b1;
    #1 chk("t6_oe_async", 32'(sda_oe), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_reg_wr", 32'(rb.reg_wr), 32'd0);
    chk("t6_reg_rd", 32'(rb.reg_rd), 32'd0);
    chk("t6_reg_addr", 32'(rb.reg_addr), 32'd0);
    chk("t6_reg_wdata", 32'(rb.reg_wdata), 32'd0);
    rst = 1'b0;
    ptr_m = 8'h00;
    repeat (5) @(posedge clk);
    rd_txn(1'b1, 8'h00, 1);

    // Random mix of writes, pointer reads, retained-pointer reads and foreign addresses
    for (int k = 0; k < 20; k++) begin
      kind = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      if (kind <= 1) begin
        a = 7'h42;
        if ($urandom_range(0, 5) == 0) a = 7'h42 ^ 7'(1 << $urandom_range(0, 6));
        for (int i = 0; i < n + 1; i++) wbuf[i] = 8'($urandom);
        wr_txn(a, n + 1);
      end else begin
        rd_txn(kind == 2, 8'($urandom), n);
      end
    end

    repeat (10) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
